cholesky_cmac_accum: RTL and testbench

// - Streaming complex conjugate multiply-accumulate stage of the complex fixed-point Cholesky kernel.
// - Consumes operand pairs (a, b) and accumulates sum(a * conj(b)) over a run closed by in_last.
// - Emits one scaled complex result per run, for the diagonal sqrt / off-diagonal divide stage.
// - Signed multipliers are inferred inside this block; it is the consumer of the kernel's multiplier outputs.

---
 rtl/cholesky_cmac_pkg.sv | 48 ++++
 rtl/cholesky_cmac_accum_if.sv | 32 +++
 rtl/cholesky_cmac_prod.sv | 46 ++++
 rtl/cholesky_cmac_accum.sv | 108 ++++++++++
 tb/tb_cholesky_cmac_accum.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/cholesky_cmac_pkg.sv
// rtl/cholesky_cmac_pkg.sv - shared widths, complex types and the output narrowing function
// Purpose : default widths, complex din/product/acc types and sat_narrow().
// Macro   : CMAC_SATURATE_EN selects saturating narrowing (else two's-complement wrap).
// Ports   : none (package).
package cholesky_cmac_pkg;

    localparam int CMAC_DIN_W      = 14;
    localparam int CMAC_ACC_W      = 32;
    localparam int CMAC_OUT_W      = 16;
    localparam int CMAC_FRAC_SHIFT = 13;
    localparam int CMAC_LEN_W      = 8;

    typedef struct packed {
        logic signed [CMAC_DIN_W-1:0] re;
        logic signed [CMAC_DIN_W-1:0] im;
    } cmac_din_t;

    typedef struct packed {
        logic signed [2*CMAC_DIN_W-1:0] re;
        logic signed [2*CMAC_DIN_W-1:0] im;
    } cmac_prod_t;

    typedef struct packed {
        logic signed [CMAC_ACC_W-1:0] re;
        logic signed [CMAC_ACC_W-1:0] im;
    } cmac_acc_t;

    // Narrows a sign-extended value to out_w bits. The result is returned
    // sign-extended to 64 bits; callers keep the low out_w bits.
    function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] value,
                                                      input int out_w);
`ifdef CMAC_SATURATE_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (value > hi)
            return hi;
        else if (value < lo)
            return lo;
        else
            return value;
`else
        return (value <<< (64 - out_w)) >>> (64 - out_w);
`endif
    endfunction

endpackage

// File: rtl/cholesky_cmac_accum_if.sv
// rtl/cholesky_cmac_accum_if.sv - operand/result handshake bundle for the CMAC stage
// Purpose : groups the operand stream (in_*) and the result stream (out_*).
// Ports   : master = producer of operands / consumer of results (testbench side),
//           slave  = the cholesky_cmac_accum block.
interface cholesky_cmac_accum_if #(
    parameter int DIN_W = 14,
    parameter int OUT_W = 16,
    parameter int LEN_W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [DIN_W-1:0] in_a_re;
    logic signed [DIN_W-1:0] in_a_im;
    logic signed [DIN_W-1:0] in_b_re;
    logic signed [DIN_W-1:0] in_b_im;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_re;
    logic signed [OUT_W-1:0] out_im;
    logic [LEN_W-1:0]        out_len;

    modport master (
        output in_valid, in_a_re, in_a_im, in_b_re, in_b_im, in_last, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_len
    );

    modport slave (
        input  in_valid, in_a_re, in_a_im, in_b_re, in_b_im, in_last, out_ready,
        output in_ready, out_valid, out_re, out_im, out_len
    );
endinterface

// File: rtl/cholesky_cmac_prod.sv
// rtl/cholesky_cmac_prod.sv - S1 register of the four signed partial products
// Purpose : registers ar*br, ai*bi, ai*br, ar*bi plus valid/last when en=1.
// Ports   : clk, rst (async, active-high), en (pipeline advance), in_valid, in_last,
//           a_re/a_im/b_re/b_im (signed DIN_W), valid, last,
//           prod_rr/prod_ii/prod_ir/prod_ri (signed 2*DIN_W).
module cholesky_cmac_prod
    import cholesky_cmac_pkg::*;
#(
    parameter int DIN_W = CMAC_DIN_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      in_valid,
    input  logic                      in_last,
    input  logic signed [DIN_W-1:0]   a_re,
    input  logic signed [DIN_W-1:0]   a_im,
    input  logic signed [DIN_W-1:0]   b_re,
    input  logic signed [DIN_W-1:0]   b_im,
    output logic                      valid,
    output logic                      last,
    output logic signed [2*DIN_W-1:0] prod_rr,
    output logic signed [2*DIN_W-1:0] prod_ii,
    output logic signed [2*DIN_W-1:0] prod_ir,
    output logic signed [2*DIN_W-1:0] prod_ri
);
    localparam int PW = 2 * DIN_W;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid   <= 1'b0;
            last    <= 1'b0;
            prod_rr <= '0;
            prod_ii <= '0;
            prod_ir <= '0;
            prod_ri <= '0;
        end else if (en) begin
            valid   <= in_valid;
            last    <= in_last;
            prod_rr <= PW'(a_re) * PW'(b_re);
            prod_ii <= PW'(a_im) * PW'(b_im);
            prod_ir <= PW'(a_im) * PW'(b_re);
            prod_ri <= PW'(a_re) * PW'(b_im);
        end
    end
endmodule

// File: rtl/cholesky_cmac_accum.sv
// rtl/cholesky_cmac_accum.sv - streaming complex conjugate multiply-accumulate stage
// Purpose : accumulates sum(a * conj(b)) over a run closed by in_last and emits one
//           scaled result (acc >>> FRAC_SHIFT, narrowed to OUT_W) per run.
// Macro   : CMAC_SATURATE_EN -> saturating narrowing; undefined -> wrap to OUT_W LSBs.
// Ports   : ap_clk, ap_rst (async, active-high),
//           io (cholesky_cmac_accum_if.slave): in_valid/in_ready, in_a_re/in_a_im,
//           in_b_re/in_b_im, in_last, out_valid/out_ready, out_re/out_im, out_len.
// Params  : DIN_W, ACC_W (>= 2*DIN_W+1, <= 64), OUT_W, FRAC_SHIFT, LEN_W.
module cholesky_cmac_accum
    import cholesky_cmac_pkg::*;
#(
    parameter int DIN_W      = CMAC_DIN_W,
    parameter int ACC_W      = CMAC_ACC_W,
    parameter int OUT_W      = CMAC_OUT_W,
    parameter int FRAC_SHIFT = CMAC_FRAC_SHIFT,
    parameter int LEN_W      = CMAC_LEN_W
) (
    input logic                 ap_clk,
    input logic                 ap_rst,
    cholesky_cmac_accum_if.slave io
);
    localparam int PW = 2 * DIN_W;

    logic                    en;
    logic                    s1_valid;
    logic                    s1_last;
    logic signed [PW-1:0]    prod_rr;
    logic signed [PW-1:0]    prod_ii;
    logic signed [PW-1:0]    prod_ir;
    logic signed [PW-1:0]    prod_ri;
    logic signed [PW:0]      p_re;
    logic signed [PW:0]      p_im;
    logic signed [ACC_W-1:0] acc_re;
    logic signed [ACC_W-1:0] acc_im;
    logic signed [ACC_W-1:0] sum_re;
    logic signed [ACC_W-1:0] sum_im;
    logic signed [ACC_W-1:0] shr_re;
    logic signed [ACC_W-1:0] shr_im;
    logic                    first;
    logic [LEN_W-1:0]        beat_cnt;

    // The whole pipeline freezes only while a result is held and not taken.
    assign en          = !(io.out_valid && !io.out_ready);
    assign io.in_ready = en;

    cholesky_cmac_prod #(
        .DIN_W (DIN_W)
    ) u_prod (
        .clk      (ap_clk),
        .rst      (ap_rst),
        .en       (en),
        .in_valid (io.in_valid),
        .in_last  (io.in_last),
        .a_re     (io.in_a_re),
        .a_im     (io.in_a_im),
        .b_re     (io.in_b_re),
        .b_im     (io.in_b_im),
        .valid    (s1_valid),
        .last     (s1_last),
        .prod_rr  (prod_rr),
        .prod_ii  (prod_ii),
        .prod_ir  (prod_ir),
        .prod_ri  (prod_ri)
    );

    // a * conj(b) = (ar*br + ai*bi) + j(ai*br - ar*bi)
    assign p_re = (PW+1)'(prod_rr) + (PW+1)'(prod_ii);
    assign p_im = (PW+1)'(prod_ir) - (PW+1)'(prod_ri);

    // First beat of a run overwrites rather than adds, so no clear cycle is needed
    // between back-to-back runs.
    assign sum_re = first ? ACC_W'(p_re) : acc_re + ACC_W'(p_re);
    assign sum_im = first ? ACC_W'(p_im) : acc_im + ACC_W'(p_im);
    assign shr_re = sum_re >>> FRAC_SHIFT;
    assign shr_im = sum_im >>> FRAC_SHIFT;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            acc_re       <= '0;
            acc_im       <= '0;
            first        <= 1'b1;
            beat_cnt     <= '0;
            io.out_valid <= 1'b0;
            io.out_re    <= '0;
            io.out_im    <= '0;
            io.out_len   <= '0;
        end else if (en) begin
            // en implies any held result is being consumed this cycle.
            io.out_valid <= s1_valid && s1_last;
            if (s1_valid) begin
                if (s1_last) begin
                    io.out_re  <= OUT_W'(sat_narrow(64'(shr_re), OUT_W));
                    io.out_im  <= OUT_W'(sat_narrow(64'(shr_im), OUT_W));
                    io.out_len <= beat_cnt + LEN_W'(1);
                    acc_re     <= '0;
                    acc_im     <= '0;
                    first      <= 1'b1;
                    beat_cnt   <= '0;
                end else begin
                    acc_re     <= sum_re;
                    acc_im     <= sum_im;
                    first      <= 1'b0;
                    beat_cnt   <= beat_cnt + LEN_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_cholesky_cmac_accum.sv
// tb/tb_cholesky_cmac_accum.sv - directed self-checking bench for cholesky_cmac_accum
module tb_cholesky_cmac_accum;
    import cholesky_cmac_pkg::*;

    localparam int DIN_W = CMAC_DIN_W;
    localparam int OUT_W = CMAC_OUT_W;
    localparam int LEN_W = CMAC_LEN_W;

`ifdef CMAC_SATURATE_EN
    localparam longint BIG_RE = 32767;
`else
    localparam longint BIG_RE = 0;
`endif

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    logic collect  = 1'b0;

    typedef struct {
        longint re;
        longint im;
        longint len;
        int     cyc;
    } res_t;
    res_t res_q[$];

    cholesky_cmac_accum_if #(.DIN_W(DIN_W), .OUT_W(OUT_W), .LEN_W(LEN_W)) io ();

    cholesky_cmac_accum #(
        .DIN_W      (DIN_W),
        .ACC_W      (CMAC_ACC_W),
        .OUT_W      (OUT_W),
        .FRAC_SHIFT (0),
        .LEN_W      (LEN_W)
    ) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .io     (io.slave)
    );

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    always @(negedge ap_clk) begin
        if (collect && io.out_valid)
            res_q.push_back('{re: longint'(io.out_re), im: longint'(io.out_im),
                              len: longint'(io.out_len), cyc: cyc});
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic cmac_din_t cx(input int re, input int im);
        cmac_din_t v;
        v.re = DIN_W'(re);
        v.im = DIN_W'(im);
        return v;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic beat(input cmac_din_t a, input cmac_din_t b, input logic last);
        int n;
        io.in_a_re  = a.re;
        io.in_a_im  = a.im;
        io.in_b_re  = b.re;
        io.in_b_im  = b.im;
        io.in_last  = last;
        io.in_valid = 1'b1;
        n = 0;
        while (!io.in_ready && n < 50) begin
            @(negedge ap_clk);
            n++;
        end
        if (n >= 50) check("beat_accept_timeout", 0, 1);
        @(negedge ap_clk);
        io.in_valid = 1'b0;
        io.in_last  = 1'b0;
    endtask

    task automatic wait_result(input string tag, input longint re, input longint im,
                               input longint len);
        int n;
        n = 0;
        while (!io.out_valid && n < 50) begin
            @(negedge ap_clk);
            n++;
        end
        check({tag, "_valid"}, longint'(io.out_valid), 1);
        check({tag, "_re"}, longint'(io.out_re), re);
        check({tag, "_im"}, longint'(io.out_im), im);
        check({tag, "_len"}, longint'(io.out_len), len);
        io.out_ready = 1'b1;
        @(negedge ap_clk);
        io.out_ready = 1'b0;
    endtask

    initial begin
        io.in_valid  = 1'b0;
        io.in_last   = 1'b0;
        io.in_a_re   = '0;
        io.in_a_im   = '0;
        io.in_b_re   = '0;
        io.in_b_im   = '0;
        io.out_ready = 1'b0;

        // reset state
        repeat (3) @(negedge ap_clk);
        check("rst_out_valid", longint'(io.out_valid), 0);
        check("rst_out_re", longint'(io.out_re), 0);
        check("rst_out_len", longint'(io.out_len), 0);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        check("rst_in_ready", longint'(io.in_ready), 1);

        // single beat, latency of two edges
        beat(cx(3, 4), cx(3, 4), 1'b1);
        check("t1_lat_edge1", longint'(io.out_valid), 0);
        @(negedge ap_clk);
        check("t1_lat_edge2", longint'(io.out_valid), 1);
        wait_result("t1", 25, 0, 1);
        check("t1_consumed", longint'(io.out_valid), 0);

        // three-beat run with a bubble: (1+7j) + (0+1j) + (-4+4j)
        beat(cx(1, 2), cx(3, -1), 1'b0);
        @(negedge ap_clk);
        beat(cx(0, 1), cx(1, 0), 1'b0);
        beat(cx(-2, 0), cx(2, 2), 1'b1);
        wait_result("t2", -3, 12, 3);

        // accumulator 2^27: wraps to 0 or saturates to 32767
        beat(cx(-8192, -8192), cx(-8192, -8192), 1'b1);
        wait_result("t3", BIG_RE, 0, 1);

        // stall: result A held, B1 frozen in S1, B2 waiting
        beat(cx(1, 0), cx(1, 0), 1'b1);
        beat(cx(2, 1), cx(1, 1), 1'b0);
        check("t4_held_valid", longint'(io.out_valid), 1);
        check("t4_held_re", longint'(io.out_re), 1);
        io.in_a_re  = DIN_W'(1);
        io.in_a_im  = DIN_W'(-1);
        io.in_b_re  = DIN_W'(0);
        io.in_b_im  = DIN_W'(1);
        io.in_last  = 1'b1;
        io.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            check($sformatf("t4_stall_ready_%0d", i), longint'(io.in_ready), 0);
            check($sformatf("t4_stall_re_%0d", i), longint'(io.out_re), 1);
        end
        check("t4_stall_len", longint'(io.out_len), 1);
        io.out_ready = 1'b1;
        @(negedge ap_clk);
        io.out_ready = 1'b0;
        io.in_valid  = 1'b0;
        io.in_last   = 1'b0;
        wait_result("t4_b", 2, -2, 2);

        // back-to-back single-beat runs, out_ready held high
        io.out_ready = 1'b1;
        collect = 1'b1;
        beat(cx(2, 0), cx(3, 0), 1'b1);
        beat(cx(0, 1), cx(1, 0), 1'b1);
        beat(cx(1, 1), cx(1, -1), 1'b1);
        repeat (4) @(negedge ap_clk);
        collect = 1'b0;
        io.out_ready = 1'b0;
        check("t5_count", longint'(res_q.size()), 3);
        if (res_q.size() == 3) begin
            check("t5_r0_re", res_q[0].re, 6);
            check("t5_r0_im", res_q[0].im, 0);
            check("t5_r1_re", res_q[1].re, 0);
            check("t5_r1_im", res_q[1].im, 1);
            check("t5_r2_re", res_q[2].re, 0);
            check("t5_r2_im", res_q[2].im, 2);
            check("t5_r2_len", res_q[2].len, 1);
            check("t5_gap01", longint'(res_q[1].cyc - res_q[0].cyc), 1);
            check("t5_gap12", longint'(res_q[2].cyc - res_q[1].cyc), 1);
        end

        // reset mid-run with a held result and a partial run in flight
        beat(cx(7, 0), cx(1, 0), 1'b1);
        beat(cx(5, 0), cx(5, 0), 1'b0);
        check("t6_pre_valid", longint'(io.out_valid), 1);
        io.in_a_re  = DIN_W'(4);
        io.in_a_im  = DIN_W'(0);
        io.in_b_re  = DIN_W'(4);
        io.in_b_im  = DIN_W'(0);
        io.in_valid = 1'b1;
        #2;
        ap_rst = 1'b1;
        #1;
        check("t6_rst_valid", longint'(io.out_valid), 0);
        check("t6_rst_re", longint'(io.out_re), 0);
        check("t6_rst_len", longint'(io.out_len), 0);
        @(negedge ap_clk);
        io.in_valid = 1'b0;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        beat(cx(2, 0), cx(3, 0), 1'b1);
        wait_result("t6_new", 6, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
